// File: rtl/cpu_types_pkg.sv
// Shared control types for the pipelined control path.
// Opcode/funct constants, ALU op encoding and the stage bundle.
package cpu_types_pkg;

   typedef enum logic [3:0] {
      ALU_SLL  = 4'd0,
      ALU_SRL  = 4'd1,
      ALU_ADD  = 4'd2,
      ALU_SUB  = 4'd3,
      ALU_AND  = 4'd4,
      ALU_OR   = 4'd5,
      ALU_XOR  = 4'd6,
      ALU_NOR  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } aluop_t;

   localparam logic [1:0] PC_NEXT = 2'd0;
   localparam logic [1:0] PC_JR   = 2'd1;
   localparam logic [1:0] PC_JUMP = 2'd2;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_HALT  = 6'h3F;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   localparam logic [4:0] REG_RA = 5'd31;

   typedef struct packed {
      aluop_t      aluop;
      logic        alusrc;
      logic [31:0] imm;
      logic [4:0]  rsel1;
      logic [4:0]  rsel2;
      logic [4:0]  wsel;
      logic        branch;
      logic        branchsel;
      logic [1:0]  pcsel;
      logic        dREN;
      logic        dWEN;
      logic        regwrite;
      logic        memtoreg;
      logic        wdatasrc;
      logic        halt;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

   function automatic logic [31:0] signExt16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

   function automatic logic [31:0] zeroExt16(input logic [15:0] v);
      return {16'h0000, v};
   endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational instruction decoder: one MIPS word -> control bundle.
// Anything outside the supported subset decodes as a bubble.
module control_decode
   import cpu_types_pkg::*;
(
   input  logic [31:0] instr,
   output ctrl_t       ctrl
);

   logic [5:0]  op;
   logic [5:0]  fn;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [15:0] imm16;
   logic [25:0] jIdx;

   assign op    = instr[31:26];
   assign rs    = instr[25:21];
   assign rt    = instr[20:16];
   assign rd    = instr[15:11];
   assign shamt = instr[10:6];
   assign fn    = instr[5:0];
   assign imm16 = instr[15:0];
   assign jIdx  = instr[25:0];

   logic       known;
   logic       writes;
   logic [4:0] dest;
   ctrl_t      raw;

   always_comb begin
      raw    = CTRL_BUBBLE;
      known  = 1'b1;
      writes = 1'b0;
      dest   = rt;
      unique case (op)
         OP_RTYPE: begin
            raw.rsel1 = rs;
            raw.rsel2 = rt;
            writes    = 1'b1;
            dest      = rd;
            unique case (fn)
               FN_SLL: begin
                  raw.aluop = ALU_SLL;
                  raw.imm   = {27'd0, shamt};
               end
               FN_SRL: begin
                  raw.aluop = ALU_SRL;
                  raw.imm   = {27'd0, shamt};
               end
               FN_JR: begin
                  raw.pcsel = PC_JR;
                  writes    = 1'b0;
               end
               FN_ADDU: raw.aluop = ALU_ADD;
               FN_SUBU: raw.aluop = ALU_SUB;
               FN_AND:  raw.aluop = ALU_AND;
               FN_OR:   raw.aluop = ALU_OR;
               FN_XOR:  raw.aluop = ALU_XOR;
               FN_NOR:  raw.aluop = ALU_NOR;
               FN_SLT:  raw.aluop = ALU_SLT;
               FN_SLTU: raw.aluop = ALU_SLTU;
               default: known = 1'b0;
            endcase
         end
         OP_ADDIU, OP_SLTI, OP_SLTIU: begin
            raw.alusrc = 1'b1;
            raw.imm    = signExt16(imm16);
            raw.rsel1  = rs;
            writes     = 1'b1;
            unique case (op)
               OP_ADDIU: raw.aluop = ALU_ADD;
               OP_SLTI:  raw.aluop = ALU_SLT;
               default:  raw.aluop = ALU_SLTU;
            endcase
         end
         OP_ANDI, OP_ORI, OP_XORI: begin
            raw.alusrc = 1'b1;
            raw.imm    = zeroExt16(imm16);
            raw.rsel1  = rs;
            writes     = 1'b1;
            unique case (op)
               OP_ANDI: raw.aluop = ALU_AND;
               OP_ORI:  raw.aluop = ALU_OR;
               default: raw.aluop = ALU_XOR;
            endcase
         end
         // LUI ORs the shifted immediate with $0
         OP_LUI: begin
            raw.aluop  = ALU_OR;
            raw.alusrc = 1'b1;
            raw.imm    = {imm16, 16'h0000};
            writes     = 1'b1;
         end
         OP_LW: begin
            raw.aluop    = ALU_ADD;
            raw.alusrc   = 1'b1;
            raw.imm      = signExt16(imm16);
            raw.rsel1    = rs;
            raw.dREN     = 1'b1;
            raw.memtoreg = 1'b1;
            writes       = 1'b1;
         end
         OP_SW: begin
            raw.aluop  = ALU_ADD;
            raw.alusrc = 1'b1;
            raw.imm    = signExt16(imm16);
            raw.rsel1  = rs;
            raw.rsel2  = rt;
            raw.dWEN   = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            raw.aluop     = ALU_SUB;
            raw.imm       = signExt16(imm16);
            raw.rsel1     = rs;
            raw.rsel2     = rt;
            raw.branch    = 1'b1;
            raw.branchsel = (op == OP_BNE);
         end
         OP_J: begin
            raw.pcsel = PC_JUMP;
            raw.imm   = {6'd0, jIdx};
         end
         OP_JAL: begin
            raw.pcsel    = PC_JUMP;
            raw.imm      = {6'd0, jIdx};
            raw.wdatasrc = 1'b1;
            writes       = 1'b1;
            dest         = REG_RA;
         end
         OP_HALT: raw.halt = 1'b1;
         default: known = 1'b0;
      endcase
      raw.wsel     = writes ? dest : 5'd0;
      raw.regwrite = writes & (dest != 5'd0);
   end

   assign ctrl = known ? raw : CTRL_BUBBLE;

endmodule

// File: rtl/control_pipe.sv
// Pipelined control: decode, then NSTAGE registered stages (EX.., MEM, WB)
// with dmem hold, stall/flush bubbles and a sticky halt.
module control_pipe
   import cpu_types_pkg::*;
#(
   parameter int NSTAGE = 3,
   parameter int WORD_W = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [WORD_W-1:0] instr,
   input  logic              instr_valid,
   input  logic              stall,
   input  logic              flush,
   input  logic              dhit,
   output logic [1:0]        dec_pcsel,
   output logic [3:0]        ex_aluop,
   output logic              ex_alusrc,
   output logic [WORD_W-1:0] ex_imm,
   output logic [4:0]        ex_rsel1,
   output logic [4:0]        ex_rsel2,
   output logic              ex_branch,
   output logic              ex_branchsel,
   output logic              mem_dREN,
   output logic              mem_dWEN,
   output logic              wb_regwrite,
   output logic [4:0]        wb_wsel,
   output logic              wb_memtoreg,
   output logic              wb_wdatasrc,
   output logic              pipe_hold,
   output logic              halt
);

   logic [31:0] instrWord;
   ctrl_t       decoded;

   assign instrWord = 32'(instr);

   control_decode uDecode (
      .instr (instrWord),
      .ctrl  (decoded)
   );

   ctrl_t stg [1:NSTAGE];
   ctrl_t ex1Next;
   logic  hold;
   logic  bubble;
   logic  loadDec;
   logic  haltSeen;
   logic  haltQ;

   assign hold = (stg[NSTAGE-1].dREN | stg[NSTAGE-1].dWEN) & ~dhit;

   // flush is kept out of bubble so fetch still sees the redirect pcsel
   assign bubble  = stall | ~instr_valid | haltSeen;
   assign loadDec = ~flush & ~bubble;
   assign ex1Next = loadDec ? decoded : CTRL_BUBBLE;

   assign dec_pcsel = bubble ? PC_NEXT : decoded.pcsel;

   for (genvar k = 1; k <= NSTAGE; k++) begin : gStage
      ctrl_t d;
      ctrl_t q;
      if (k == 1) begin : gHead
         assign d = ex1Next;
      end else begin : gTail
         assign d = stg[k-1];
      end
      always_ff @(posedge CLK or posedge RST) begin
         if (RST) begin
            q <= CTRL_BUBBLE;
         end else if (!hold) begin
            q <= d;
         end
      end
      assign stg[k] = q;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         haltSeen <= 1'b0;
         haltQ    <= 1'b0;
      end else begin
         if (!hold && loadDec && decoded.halt) begin
            haltSeen <= 1'b1;
         end
         if (stg[NSTAGE].halt) begin
            haltQ <= 1'b1;
         end
      end
   end

   assign ex_aluop     = stg[1].aluop;
   assign ex_alusrc    = stg[1].alusrc;
   assign ex_imm       = WORD_W'(stg[1].imm);
   assign ex_rsel1     = stg[1].rsel1;
   assign ex_rsel2     = stg[1].rsel2;
   assign ex_branch    = stg[1].branch;
   assign ex_branchsel = stg[1].branchsel;
   assign mem_dREN     = stg[NSTAGE-1].dREN;
   assign mem_dWEN     = stg[NSTAGE-1].dWEN;
   assign wb_regwrite  = stg[NSTAGE].regwrite;
   assign wb_wsel      = stg[NSTAGE].wsel;
   assign wb_memtoreg  = stg[NSTAGE].memtoreg;
   assign wb_wdatasrc  = stg[NSTAGE].wdatasrc;
   assign pipe_hold    = hold;
   assign halt         = haltQ;

endmodule
